// File: rtl/chord_note_sequencer.sv
`timescale 1ns/1ps
// Note sequencer for the chords datapath: buffers {freq, duration} events in a small
// queue and plays them one at a time, timing notes and gaps in audio sample ticks.
module chord_note_sequencer #(
  parameter int FREQ_BITS   = 24,
  parameter int DUR_BITS    = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int GAP_SAMPLES = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          new_sample_ready,
  input  logic                          note_valid,
  output logic                          note_ready,
  input  logic [FREQ_BITS-1:0]          note_freq,
  input  logic [DUR_BITS-1:0]           note_duration,
  input  logic                          flush,
  output logic [FREQ_BITS-1:0]          base_note_freq,
  output logic                          base_note_active,
  output logic                          note_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [1:0]                    dbg_state_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = (GAP_SAMPLES < 2) ? 1 : $clog2(GAP_SAMPLES + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [GAP_W-1:0] GAP_C   = GAP_W'(GAP_SAMPLES);

  logic [1:0]           state_q, state_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [FREQ_BITS-1:0] freq_q, freq_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;
  logic [DUR_BITS-1:0]  remaining_q, remaining_d;
  logic [GAP_W-1:0]     gap_q, gap_d;

  logic [FREQ_BITS-1:0] freq_mem_q [FIFO_DEPTH];
  logic [DUR_BITS-1:0]  dur_mem_q  [FIFO_DEPTH];

  logic                 accept;
  logic                 push;
  logic                 pop;
  logic [FREQ_BITS-1:0] head_freq;
  logic [DUR_BITS-1:0]  head_dur;

  // Handshake: a note transfers on any rising edge where note_valid && note_ready.
  // note_ready depends only on the registered count plus reset/flush, never on note_valid.
  // A transferred zero-duration note is acknowledged but never stored.
  assign note_ready = reset && (count_q < DEPTH_C) && !flush;
  assign accept     = note_valid && note_ready;
  assign push       = accept && (note_duration != '0);
  assign pop        = reset && !flush && (state_q == ST_IDLE) && (count_q != '0);

  assign head_freq  = freq_mem_q[rd_ptr_q];
  assign head_dur   = dur_mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    freq_d      = freq_q;
    active_d    = active_q;
    done_d      = 1'b0;
    remaining_d = remaining_q;
    gap_d       = gap_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          freq_d      = head_freq;
          active_d    = 1'b1;
          remaining_d = head_dur;
          state_d     = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (new_sample_ready) begin
          // Saturating compare keeps the counter from ever wrapping below zero.
          if (remaining_q <= DUR_BITS'(1)) begin
            active_d    = 1'b0;
            done_d      = 1'b1;
            remaining_d = '0;
            if (GAP_SAMPLES == 0) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_GAP;
              gap_d   = GAP_C;
            end
          end else begin
            remaining_d = remaining_q - DUR_BITS'(1);
          end
        end
      end
      ST_GAP: begin
        if (new_sample_ready) begin
          if (gap_q <= GAP_W'(1)) begin
            gap_d   = '0;
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush silences the output but keeps the last frequency on base_note_freq.
    if (flush) begin
      state_d     = ST_IDLE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      active_d    = 1'b0;
      done_d      = 1'b0;
      remaining_d = '0;
      gap_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      freq_q      <= '0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      freq_q      <= freq_d;
      active_q    <= active_d;
      done_q      <= done_d;
      remaining_q <= remaining_d;
      gap_q       <= gap_d;
    end
  end

  // Queue storage carries no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      freq_mem_q[wr_ptr_q] <= note_freq;
      dur_mem_q[wr_ptr_q]  <= note_duration;
    end
  end

  assign base_note_freq   = freq_q;
  assign base_note_active = active_q;
  assign note_done        = done_q;
  assign fifo_count       = count_q;
  assign busy             = (state_q != ST_IDLE) || (count_q != '0);
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_chord_note_sequencer.sv
`timescale 1ns/1ps
// Bench for chord_note_sequencer: directed scenarios plus random traffic, all checked
// each cycle against a tick-counting queue model of the sequencer.
module tb_chord_note_sequencer;

  localparam int FREQ_BITS   = 24;
  localparam int DUR_BITS    = 16;
  localparam int FIFO_DEPTH  = 4;
  localparam int GAP_SAMPLES = 8;
  localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam int W           = FREQ_BITS + DUR_BITS;
  localparam int VW          = 1 + CNT_W + FREQ_BITS + 3;

  // ---------------- clock / reset / DUT ----------------
  logic                 clk = 1'b0;
  logic                 reset;
  logic                 tick_auto;
  logic                 tick_man;
  logic                 new_sample_ready;
  logic                 note_valid;
  logic                 note_ready;
  logic [FREQ_BITS-1:0] note_freq;
  logic [DUR_BITS-1:0]  note_duration;
  logic                 flush;
  logic [FREQ_BITS-1:0] base_note_freq;
  logic                 base_note_active;
  logic                 note_done;
  logic                 busy;
  logic [CNT_W-1:0]     fifo_count;
  logic [1:0]           dbg_state;

  always #5 clk = ~clk;

  assign new_sample_ready = tick_auto | tick_man;

  chord_note_sequencer #(
    .FREQ_BITS  (FREQ_BITS),
    .DUR_BITS   (DUR_BITS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .GAP_SAMPLES(GAP_SAMPLES)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .new_sample_ready(new_sample_ready),
    .note_valid      (note_valid),
    .note_ready      (note_ready),
    .note_freq       (note_freq),
    .note_duration   (note_duration),
    .flush           (flush),
    .base_note_freq  (base_note_freq),
    .base_note_active(base_note_active),
    .note_done       (note_done),
    .busy            (busy),
    .fifo_count      (fifo_count),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- periodic sample tick ----------------
  logic tick_en;
  int   tick_period;
  int   tick_ctr = 0;

  initial begin
    tick_auto = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (tick_en && tick_ctr >= tick_period - 1) begin
        tick_auto = 1'b1;
        tick_ctr  = 0;
      end else begin
        tick_auto = 1'b0;
        if (tick_en) tick_ctr++;
      end
    end
  end

  // ---------------- reference model ----------------
  // Pending notes, ticks still to sound, silent ticks still to wait.
  logic [W-1:0]         exp_q[$];
  int                   m_sound = 0;
  int                   m_gap   = 0;
  logic [FREQ_BITS-1:0] m_freq  = '0;
  logic                 m_done  = 1'b0;
  bit                   m_take;
  logic [W-1:0]         m_head;

  always @(posedge clk) begin
    if (!reset) begin
      exp_q.delete();
      m_sound = 0;
      m_gap   = 0;
      m_freq  = '0;
      m_done  = 1'b0;
    end else if (flush) begin
      exp_q.delete();
      m_sound = 0;
      m_gap   = 0;
      m_done  = 1'b0;
    end else begin
      m_take = note_valid && (exp_q.size() < FIFO_DEPTH);
      m_done = 1'b0;
      if (m_sound > 0) begin
        if (new_sample_ready) begin
          m_sound--;
          if (m_sound == 0) begin
            m_done = 1'b1;
            m_gap  = GAP_SAMPLES;
          end
        end
      end else if (m_gap > 0) begin
        if (new_sample_ready) m_gap--;
      end else if (exp_q.size() > 0) begin
        m_head  = exp_q.pop_front();
        m_freq  = m_head[W-1:DUR_BITS];
        m_sound = int'(m_head[DUR_BITS-1:0]);
      end
      if (m_take && note_duration != '0) exp_q.push_back({note_freq, note_duration});
    end
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Observed statistics, all maintained by step().
  int                   done_pulses, act_ticks, gap_ticks, win_max;
  logic [FREQ_BITS-1:0] play_log[$];
  logic                 prev_active = 1'b0;
  logic                 prev_busy   = 1'b0;
  logic                 in_gap      = 1'b0;
  logic                 prev_in_gap = 1'b0;
  logic [VW-1:0]        exp_vec, act_vec;

  task automatic clear_stats();
    done_pulses = 0;
    act_ticks   = 0;
    gap_ticks   = 0;
    win_max     = 0;
    play_log.delete();
  endtask

  // One clock cycle: compare all outputs with the model, update statistics,
  // and return at a point where the caller may drive inputs.
  task automatic step();
    @(negedge clk);
    #1;
    exp_vec = {reset && (exp_q.size() < FIFO_DEPTH) && !flush, CNT_W'(exp_q.size()), m_freq,
               m_sound > 0, m_done, (m_sound > 0) || (m_gap > 0) || (exp_q.size() > 0)};
    act_vec = {note_ready, fifo_count, base_note_freq, base_note_active, note_done, busy};
    checks++;
    if (act_vec !== exp_vec) begin
      errors++;
      $display("FAIL outputs t=%0t: got rdy=%b cnt=%0d freq=%0d act=%b done=%b busy=%b st=%0d; expected rdy=%b cnt=%0d freq=%0d act=%b done=%b busy=%b",
               $time, note_ready, fifo_count, base_note_freq, base_note_active, note_done, busy,
               dbg_state, exp_vec[VW-1], exp_vec[VW-2 -: CNT_W], exp_vec[FREQ_BITS+2:3],
               exp_vec[2], exp_vec[1], exp_vec[0]);
    end
    if (note_done) done_pulses++;
    if (base_note_active && !prev_active) play_log.push_back(base_note_freq);
    if (new_sample_ready && prev_active) act_ticks++;
    if (new_sample_ready && prev_in_gap && !prev_active && prev_busy) gap_ticks++;
    if (note_done) in_gap = 1'b1;
    if (base_note_active || !busy) in_gap = 1'b0;
    if (int'(fifo_count) > win_max) win_max = int'(fifo_count);
    prev_active = base_note_active;
    prev_busy   = busy;
    prev_in_gap = in_gap;
    #1;
  endtask

  // ---------------- driver tasks ----------------
  int   push_wait;
  logic last_wait_act, ready_act;
  int   last_wait_cnt, ready_cnt;

  task automatic push_note(input logic [FREQ_BITS-1:0] f, input logic [DUR_BITS-1:0] d);
    note_valid    = 1'b1;
    note_freq     = f;
    note_duration = d;
    #1;
    push_wait     = 0;
    last_wait_act = 1'b0;
    last_wait_cnt = 0;
    while (!note_ready && push_wait < 3000) begin
      last_wait_act = base_note_active;
      last_wait_cnt = int'(fifo_count);
      step();
      push_wait++;
    end
    ready_act = base_note_active;
    ready_cnt = int'(fifo_count);
    check("push_ready_within_budget", note_ready, 1);
    step();
    note_valid = 1'b0;
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    check("idle_within_budget", busy, 0);
  endtask

  task automatic man_tick();
    tick_man = 1'b1;
    step();
    tick_man = 1'b0;
    repeat (4) step();
  endtask

  // ---------------- stimulus ----------------
  logic [FREQ_BITS-1:0] seq_f [5];

  initial begin
    reset         = 1'b0;
    note_valid    = 1'b1;
    note_freq     = 24'd123;
    note_duration = 16'd5;
    flush         = 1'b0;
    tick_man      = 1'b0;
    tick_en       = 1'b0;
    tick_period   = 100;
    clear_stats();

    // Reset held with a note offered: nothing may be accepted.
    repeat (5) step();
    check("rst_note_ready", note_ready, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_freq", base_note_freq, 0);
    check("rst_active", base_note_active, 0);
    check("rst_done", note_done, 0);
    check("rst_busy", busy, 0);
    reset      = 1'b1;
    note_valid = 1'b0;
    #1;
    check("post_rst_ready", note_ready, 1);
    check("post_rst_count", fifo_count, 0);
    step();
    step();

    // Single note.
    tick_en = 1'b1;
    clear_stats();
    push_note(24'd60000, 16'd10);
    run_until_idle(4000);
    check("single_active_ticks", act_ticks, 10);
    check("single_played", play_log.size(), 1);
    check("single_freq", play_log[0], 60000);
    check("single_done_pulses", done_pulses, 1);
    check("single_gap_ticks", gap_ticks, GAP_SAMPLES);

    // Back-to-back queue of five notes.
    seq_f[0] = 24'd60000; seq_f[1] = 24'd110000; seq_f[2] = 24'd60000;
    seq_f[3] = 24'd110000; seq_f[4] = 24'd60000;
    clear_stats();
    for (int i = 0; i < 5; i++) push_note(seq_f[i], 16'd4);
    run_until_idle(12000);
    check("b2b_done_pulses", done_pulses, 5);
    check("b2b_played", play_log.size(), 5);
    for (int i = 0; i < 5; i++) check($sformatf("b2b_order_%0d", i), play_log[i], seq_f[i]);
    check("b2b_active_ticks", act_ticks, 20);
    check("b2b_gap_ticks", gap_ticks, 5 * GAP_SAMPLES);

    // Zero-duration note is acknowledged but dropped.
    clear_stats();
    push_note(24'd50000, 16'd0);
    push_note(24'd70000, 16'd3);
    run_until_idle(4000);
    check("zero_max_count", win_max, 1);
    check("zero_played", play_log.size(), 1);
    check("zero_freq", play_log[0], 70000);
    check("zero_done_pulses", done_pulses, 1);
    check("zero_active_ticks", act_ticks, 3);

    // Flush on the fifth tick of the first note, with a note offered at the same time.
    tick_en = 1'b0;
    repeat (6) step();
    clear_stats();
    push_note(24'd30000, 16'd20);
    push_note(24'd40000, 16'd20);
    push_note(24'd50000, 16'd20);
    check("flush_pre_active", base_note_active, 1);
    repeat (4) man_tick();
    check("flush_pre_ticks", act_ticks, 4);
    tick_man      = 1'b1;
    flush         = 1'b1;
    note_valid    = 1'b1;
    note_freq     = 24'd90000;
    note_duration = 16'd7;
    step();
    tick_man   = 1'b0;
    flush      = 1'b0;
    note_valid = 1'b0;
    check("flush_active", base_note_active, 0);
    check("flush_count", fifo_count, 0);
    check("flush_busy", busy, 0);
    check("flush_done", note_done, 0);
    check("flush_freq_held", base_note_freq, 30000);
    repeat (10) step();
    check("flush_no_done_pulse", done_pulses, 0);
    check("flush_count_later", fifo_count, 0);

    // Full queue: offered note waits through the pop cycle, enters the cycle after.
    tick_period = 20;
    tick_en     = 1'b1;
    clear_stats();
    for (int i = 1; i <= 5; i++) push_note(FREQ_BITS'(i * 1000), 16'd2);
    push_note(24'd6000, 16'd2);
    check("full_waited", push_wait > 0, 1);
    check("full_pop_cycle_count", last_wait_cnt, FIFO_DEPTH);
    check("full_pop_cycle_active", last_wait_act, 0);
    check("full_accept_cycle_count", ready_cnt, FIFO_DEPTH - 1);
    check("full_accept_cycle_active", ready_act, 1);
    check("full_refilled", fifo_count, FIFO_DEPTH);
    run_until_idle(6000);
    check("full_done_pulses", done_pulses, 6);
    check("full_played", play_log.size(), 6);
    check("full_last_freq", play_log[5], 6000);

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 150; i++) begin
      tick_period = $urandom_range(3, 6);
      case ($urandom_range(0, 24))
        0: begin
          flush         = 1'b1;
          note_valid    = 1'($urandom_range(0, 1));
          note_freq     = FREQ_BITS'($urandom);
          note_duration = 16'd5;
          step();
          flush      = 1'b0;
          note_valid = 1'b0;
        end
        1: begin
          reset = 1'b0;
          step();
          reset = 1'b1;
        end
        default: begin
          push_note(FREQ_BITS'($urandom),
                    ($urandom_range(0, 4) == 0) ? 16'd0 : DUR_BITS'($urandom_range(1, 6)));
        end
      endcase
      repeat ($urandom_range(0, 15)) step();
    end
    run_until_idle(6000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
